parser_input_arbiter: RTL

- Packet-atomic round-robin arbiter that shares the single parser receive interface (dataIn/dataIn_val/dataIn_ready/dataIN_last) among NUM_SRC upstream packet sources.
- Holds a grant from the header beat through the last beat, so packets never interleave.
- Monitors each forwarded packet's header length field against the actual beat count and flags format errors.
- Sits directly in front of the parser; does not modify data.

---
 rtl/parser_pkg.sv | 23 ++
 rtl/parser_input_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 31 +++
 rtl/parser_input_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared constants and types for the parser input side: header field positions,
// packet sizing rules and the arbiter state encoding.
package parser_pkg;

    localparam int unsigned HDR_LEN_MSB    = 31;
    localparam int unsigned HDR_LEN_LSB    = 16;
    localparam int unsigned HDR_STREAM_MSB = 15;
    localparam int unsigned MIN_PKT_BYTES  = 8;
    localparam int unsigned WORD_BYTES     = 4;

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Words needed to carry a header byte length; 17-bit sum so 0xFFFF does not wrap.
    function automatic logic [15:0] hdr_exp_beats(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'(WORD_BYTES - 1);
        return {2'b00, sum[16:2]};
    endfunction

endpackage

// File: rtl/parser_input_arbiter_if.sv
// Bundle of the per-source upstream handshakes, the parser receive handshake and
// the grant/format-error status outputs of the input arbiter.
interface parser_input_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = 2
);

    logic [NUM_SRC*32-1:0] src_data;
    logic [NUM_SRC-1:0]    src_val;
    logic [NUM_SRC-1:0]    src_last;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC-1:0]    src_enable;
    logic [31:0]           dataIn;
    logic                  dataIn_val;
    logic                  dataIN_last;
    logic                  dataIn_ready;
    logic                  grant_val;
    logic [SRC_W-1:0]      grant_id;
    logic                  fmt_err;
    logic [SRC_W-1:0]      fmt_err_src;

    modport master (
        input  src_data, src_val, src_last, src_enable, dataIn_ready,
        output src_ready, dataIn, dataIn_val, dataIN_last,
        output grant_val, grant_id, fmt_err, fmt_err_src
    );

    modport slave (
        output src_data, src_val, src_last, src_enable, dataIn_ready,
        input  src_ready, dataIn, dataIn_val, dataIN_last,
        input  grant_val, grant_id, fmt_err, fmt_err_src
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// explicitly at NUM_SRC so non-power-of-two source counts work.
module rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               any,
    output logic [SRC_W-1:0]   idx
);

    always_comb begin
        int w_cand;
        any    = 1'b0;
        idx    = '0;
        w_cand = 0;
        // Walk from the farthest candidate back to ptr so the nearest hit wins.
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            w_cand = int'(ptr) + i;
            if (w_cand >= int'(NUM_SRC)) begin
                w_cand = w_cand - int'(NUM_SRC);
            end
            if (req[w_cand]) begin
                any = 1'b1;
                idx = SRC_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/parser_input_arbiter.sv
// Packet-atomic round-robin arbiter feeding the parser; holds a grant header to
// last beat and flags packets whose header length disagrees with the beat count.
module parser_input_arbiter
    import parser_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = 2
) (
    input logic                    clk,
    input logic                    reset,
    parser_input_arbiter_if.master bus
);

    arb_state_e       r_state, w_state_d;
    logic [SRC_W-1:0] r_rr_ptr, w_rr_ptr_d;
    logic [SRC_W-1:0] r_grant_id, w_grant_id_d;
    logic [SRC_W-1:0] r_fmt_err_src, w_fmt_err_src_d;
    logic             r_grant_val, w_grant_val_d;
    logic             r_fmt_err, w_fmt_err_d;
    logic             r_short, w_short_d;
    logic [15:0]      r_beat_cnt, w_beat_cnt_d;
    logic [15:0]      r_exp_beats, w_exp_beats_d;

    logic [31:0]        w_words [NUM_SRC];
    logic [NUM_SRC-1:0] w_req;
    logic               w_pick_any;
    logic [SRC_W-1:0]   w_pick_idx;
    logic               w_beat;
    logic               w_hdr_beat;
    logic [15:0]        w_hdr_len;
    logic [15:0]        w_cur_exp;
    logic               w_cur_short;
    logic [16:0]        w_cnt_inc;
    logic               w_err;

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_words
        assign w_words[g] = bus.src_data[g*32 +: 32];
    end

    assign w_req = bus.src_val & bus.src_enable;

    rr_pick #(
        .NUM_SRC(NUM_SRC),
        .SRC_W  (SRC_W)
    ) u_rr_pick (
        .req(w_req),
        .ptr(r_rr_ptr),
        .any(w_pick_any),
        .idx(w_pick_idx)
    );

    // A single-beat packet is judged on its own header, not the stale latched one.
    assign w_beat      = (r_state == BUSY) && bus.dataIn_val && bus.dataIn_ready;
    assign w_hdr_beat  = w_beat && (r_beat_cnt == '0);
    assign w_hdr_len   = bus.dataIn[HDR_LEN_MSB:HDR_LEN_LSB];
    assign w_cur_exp   = w_hdr_beat ? hdr_exp_beats(w_hdr_len) : r_exp_beats;
    assign w_cur_short = w_hdr_beat ? (w_hdr_len < 16'(MIN_PKT_BYTES)) : r_short;
    assign w_cnt_inc   = {1'b0, r_beat_cnt} + 17'd1;
    assign w_err       = (w_cnt_inc != {1'b0, w_cur_exp}) || w_cur_short;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ARB;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_val   <= 1'b0;
            r_beat_cnt    <= '0;
            r_exp_beats   <= '0;
            r_short       <= 1'b0;
            r_fmt_err     <= 1'b0;
            r_fmt_err_src <= '0;
        end else begin
            r_state       <= w_state_d;
            r_rr_ptr      <= w_rr_ptr_d;
            r_grant_id    <= w_grant_id_d;
            r_grant_val   <= w_grant_val_d;
            r_beat_cnt    <= w_beat_cnt_d;
            r_exp_beats   <= w_exp_beats_d;
            r_short       <= w_short_d;
            r_fmt_err     <= w_fmt_err_d;
            r_fmt_err_src <= w_fmt_err_src_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_rr_ptr_d      = r_rr_ptr;
        w_grant_id_d    = r_grant_id;
        w_grant_val_d   = r_grant_val;
        w_beat_cnt_d    = r_beat_cnt;
        w_exp_beats_d   = r_exp_beats;
        w_short_d       = r_short;
        w_fmt_err_d     = 1'b0;
        w_fmt_err_src_d = r_fmt_err_src;
        unique case (r_state)
            ARB: begin
                if (w_pick_any) begin
                    w_state_d     = BUSY;
                    w_grant_id_d  = w_pick_idx;
                    w_grant_val_d = 1'b1;
                    w_beat_cnt_d  = '0;
                end
            end
            BUSY: begin
                if (w_beat) begin
                    if (w_hdr_beat) begin
                        w_exp_beats_d = w_cur_exp;
                        w_short_d     = w_cur_short;
                    end
                    if (r_beat_cnt != 16'hFFFF) begin
                        w_beat_cnt_d = w_cnt_inc[15:0];
                    end
                    if (bus.dataIN_last) begin
                        w_state_d     = ARB;
                        w_grant_val_d = 1'b0;
                        w_rr_ptr_d    = (r_grant_id == SRC_W'(NUM_SRC - 1)) ? '0
                                                                           : r_grant_id + 1'b1;
                        if (w_err) begin
                            w_fmt_err_d     = 1'b1;
                            w_fmt_err_src_d = r_grant_id;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.dataIn      = '0;
        bus.dataIn_val  = 1'b0;
        bus.dataIN_last = 1'b0;
        bus.src_ready   = '0;
        if (r_state == BUSY) begin
            bus.dataIn                = w_words[r_grant_id];
            bus.dataIn_val            = bus.src_val[r_grant_id];
            bus.dataIN_last           = bus.src_last[r_grant_id];
            bus.src_ready[r_grant_id] = bus.dataIn_ready;
        end
    end

    assign bus.grant_val   = r_grant_val;
    assign bus.grant_id    = r_grant_id;
    assign bus.fmt_err     = r_fmt_err;
    assign bus.fmt_err_src = r_fmt_err_src;

endmodule
